// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: FWFT buffer with per-entry error tags, sticky overrun and error counters.
// Define UART_RX_FIFO_DROP_BAD_EN to discard frames that carry a parity or framing error.
module uart_rx_fifo #(
    parameter int DBIT      = 8,
    parameter int ADDR_W    = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DBIT-1:0]      rx_data,
    input  logic                 rx_done,
    input  logic                 rx_err,
    input  logic                 fr_err,
    input  logic                 rd,
    output logic [DBIT-1:0]      r_data,
    output logic                 r_par_err,
    output logic                 r_fr_err,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_W:0]      count,
    output logic                 overrun,
    input  logic                 clr_status,
    output logic [ERR_CNT_W-1:0] par_err_cnt,
    output logic [ERR_CNT_W-1:0] fr_err_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int EW    = DBIT + 2;
    localparam logic [ADDR_W-1:0]    PTR_ONE  = 1;
    localparam logic [ADDR_W:0]      CNT_ONE  = 1;
    localparam logic [ADDR_W:0]      CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE  = 1;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    logic [EW-1:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic                 par_pend_q, par_pend_d;
    logic                 overrun_q, overrun_d;
    logic [ERR_CNT_W-1:0] par_cnt_q, par_cnt_d;
    logic [ERR_CNT_W-1:0] fr_cnt_q, fr_cnt_d;

    logic          par_tag;
    logic          store;
    logic          do_rd;
    logic          we;
    logic          drop;
    logic [EW-1:0] head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign head  = mem_q[rd_ptr_q];

    // A parity pulse seen earlier in the frame is folded into this frame's tag
    assign par_tag = par_pend_q | rx_err;

`ifdef UART_RX_FIFO_DROP_BAD_EN
    assign store = rx_done & ~par_tag & ~fr_err;
`else
    assign store = rx_done;
`endif

    assign do_rd = rd & ~empty;
    assign we    = store & (~full | do_rd);
    assign drop  = store & full & ~rd;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        par_pend_d = par_pend_q;
        overrun_d  = overrun_q;
        par_cnt_d  = par_cnt_q;
        fr_cnt_d   = fr_cnt_q;

        if (we) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (we && !do_rd) count_d = count_q + CNT_ONE;
        else if (!we && do_rd) count_d = count_q - CNT_ONE;

        if (rx_done) par_pend_d = 1'b0;
        else if (rx_err) par_pend_d = 1'b1;

        if (drop) overrun_d = 1'b1;
        if (rx_done && par_tag && par_cnt_q != ERR_MAX)
            par_cnt_d = par_cnt_q + ERR_ONE;
        if (rx_done && fr_err && fr_cnt_q != ERR_MAX)
            fr_cnt_d = fr_cnt_q + ERR_ONE;

        // Clearing wins over any same-cycle status event
        if (clr_status) begin
            overrun_d = 1'b0;
            par_cnt_d = '0;
            fr_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            par_pend_q <= 1'b0;
            overrun_q  <= 1'b0;
            par_cnt_q  <= '0;
            fr_cnt_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            par_pend_q <= par_pend_d;
            overrun_q  <= overrun_d;
            par_cnt_q  <= par_cnt_d;
            fr_cnt_q   <= fr_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[wr_ptr_q] <= {fr_err, par_tag, rx_data};
    end

    always_comb begin
        r_data    = '0;
        r_par_err = 1'b0;
        r_fr_err  = 1'b0;
        if (!empty) begin
            r_data = head[DBIT-1:0];
`ifndef UART_RX_FIFO_DROP_BAD_EN
            r_par_err = head[DBIT];
            r_fr_err  = head[DBIT+1];
`endif
        end
    end

    assign count       = count_q;
    assign overrun     = overrun_q;
    assign par_err_cnt = par_cnt_q;
    assign fr_err_cnt  = fr_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: vector table plus scoreboard-tracked corner sequences.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0;
    logic       rx_err = 1'b0;
    logic       fr_err = 1'b0;
    logic       rd = 1'b0;
    logic       clr_status = 1'b0;
    logic [7:0] r_data;
    logic       r_par_err;
    logic       r_fr_err;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic [7:0] par_err_cnt;
    logic [7:0] fr_err_cnt;

    uart_rx_fifo dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .rx_err(rx_err), .fr_err(fr_err), .rd(rd), .r_data(r_data),
        .r_par_err(r_par_err), .r_fr_err(r_fr_err), .empty(empty),
        .full(full), .count(count), .overrun(overrun),
        .clr_status(clr_status), .par_err_cnt(par_err_cnt),
        .fr_err_cnt(fr_err_cnt)
    );

    always #5 clk = ~clk;

`ifdef UART_RX_FIFO_DROP_BAD_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    logic [9:0] sb[$];
    int m_par = 0;
    int m_fr = 0;
    bit m_ovr = 1'b0;

    typedef struct {
        logic [7:0] d;
        int         pe;
        bit         fe;
        bit         ep;
        bit         ef;
    } vec_t;
    vec_t tbl[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic check_state(string nm);
        logic [9:0] e;
        chk({nm, ".count"}, 32'(count), 32'(sb.size()));
        chk({nm, ".empty"}, 32'(empty), 32'(sb.size() == 0));
        chk({nm, ".full"}, 32'(full), 32'(sb.size() == 16));
        chk({nm, ".ovr"}, 32'(overrun), 32'(m_ovr));
        chk({nm, ".pcnt"}, 32'(par_err_cnt), 32'(m_par));
        chk({nm, ".fcnt"}, 32'(fr_err_cnt), 32'(m_fr));
        e = (sb.size() == 0) ? 10'h0 : sb[0];
        chk({nm, ".data"}, 32'(r_data), 32'(e[7:0]));
        chk({nm, ".ptag"}, 32'(r_par_err), DROP ? 32'd0 : 32'(e[8]));
        chk({nm, ".ftag"}, 32'(r_fr_err), DROP ? 32'd0 : 32'(e[9]));
    endtask

    // pe: 0 none, 1 parity pulse 3 cycles before done, 2 coincident with done
    task automatic send(string nm, logic [7:0] d, int pe, bit fe, bit r, bit clr);
        bit pt;
        bit st;
        int n;
        if (pe == 1) begin
            rx_err = 1'b1;
            step();
            rx_err = 1'b0;
            step();
            step();
        end
        pt = (pe != 0);
        rx_data = d;
        rx_done = 1'b1;
        rx_err = (pe == 2);
        fr_err = fe;
        rd = r;
        clr_status = clr;
        n = sb.size();
        st = DROP ? !(pt || fe) : 1'b1;
        if (r && n > 0) void'(sb.pop_front());
        if (st) begin
            if (n < 16 || (r && n > 0)) sb.push_back({fe, pt, d});
            else m_ovr = 1'b1;
        end
        if (pt && m_par < 255) m_par++;
        if (fe && m_fr < 255) m_fr++;
        if (clr) begin
            m_par = 0;
            m_fr = 0;
            m_ovr = 1'b0;
        end
        step();
        rx_done = 1'b0;
        rx_err = 1'b0;
        fr_err = 1'b0;
        rd = 1'b0;
        clr_status = 1'b0;
        check_state(nm);
    endtask

    task automatic pop(string nm);
        rd = 1'b1;
        if (sb.size() > 0) void'(sb.pop_front());
        step();
        rd = 1'b0;
        check_state(nm);
    endtask

    task automatic do_clr();
        clr_status = 1'b1;
        m_par = 0;
        m_fr = 0;
        m_ovr = 1'b0;
        step();
        clr_status = 1'b0;
        check_state("clr");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        m_par = 0;
        m_fr = 0;
        m_ovr = 1'b0;
        step();
        check_state("reset");
    endtask

    initial begin
        tbl[0] = '{8'h5A, 0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h33, 1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'hC4, 0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'h00, 0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{8'h96, 2, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{8'h11, 0, 1'b0, 1'b0, 1'b0};

        step();
        check_state("por");
        reset = 1'b0;
        step();
        check_state("idle");

        for (int i = 0; i < 6; i++) begin
            send("tbl", tbl[i].d, tbl[i].pe, tbl[i].fe, 1'b0, 1'b0);
            if (DROP) begin
                chk("tbl.empty", 32'(empty), 32'(tbl[i].ep | tbl[i].ef));
            end else begin
                chk("tbl.rdata", 32'(r_data), 32'(tbl[i].d));
                chk("tbl.ptag", 32'(r_par_err), 32'(tbl[i].ep));
                chk("tbl.ftag", 32'(r_fr_err), 32'(tbl[i].ef));
            end
            pop("tbl_pop");
        end
        chk("tbl.pcnt", 32'(par_err_cnt), 32'd2);
        chk("tbl.fcnt", 32'(fr_err_cnt), 32'd1);

        pop("rd_empty");

        for (int i = 0; i < 16; i++)
            send("fill", 8'(i), 0, 1'b0, 1'b0, 1'b0);
        chk("fill.full", 32'(full), 32'd1);
        send("ovr", 8'hFF, 0, 1'b0, 1'b0, 1'b0);
        chk("ovr.flag", 32'(overrun), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("drain.order", 32'(r_data), 32'(i));
            pop("drain");
        end
        chk("drain.empty", 32'(empty), 32'd1);
        do_clr();

        for (int i = 0; i < 16; i++)
            send("fill2", 8'(8'h40 + i), 0, 1'b0, 1'b0, 1'b0);
        send("wr_rd_full", 8'hAB, 0, 1'b0, 1'b1, 1'b0);
        chk("wr_rd.count", 32'(count), 32'd16);
        chk("wr_rd.ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < 15; i++) pop("drain2");
        chk("last.ab", 32'(r_data), 32'hAB);
        pop("drain2");
        for (int i = 0; i < 20; i++) begin
            send("wrap", 8'(8'hE0 + i), 0, 1'b0, 1'b0, 1'b0);
            send("wrap_rd", 8'(8'h10 + i), 0, 1'b0, 1'b1, 1'b0);
        end
        while (sb.size() > 0) pop("wrap_drain");

        for (int i = 0; i < 300; i++)
            send("sat", 8'(i), 2, 1'b0, 1'b0, 1'b0);
        chk("sat.pcnt", 32'(par_err_cnt), 32'd255);
        send("clr_hit", 8'h77, 2, 1'b0, 1'b0, 1'b1);
        chk("clr.pcnt", 32'(par_err_cnt), 32'd0);
        chk("clr.ovr", 32'(overrun), 32'd0);

        rx_err = 1'b1;
        step();
        rx_err = 1'b0;
        do_reset();
        send("post_rst", 8'h3C, 0, 1'b0, 1'b0, 1'b0);
        chk("post_rst.ptag", 32'(r_par_err), 32'd0);
        chk("post_rst.data", 32'(r_data), 32'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
